// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage constants and sequencer state encoding
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [31:0] DEF_BOOT_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - single-entry pending redirect register
module pc_redirect_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         pend_vld,
  output logic [W-1:0] pend_data
);

  // load wins over clear so a newer redirect always overwrites an older one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else if (load) begin
      pend_vld  <= 1'b1;
      pend_data <= load_data;
    end else if (clear) begin
      pend_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller and imem request FSM; PC_SEQ_MISALIGN_TRAP_EN enables misaligned-target trap
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEF_BOOT_ADDR,
  parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_cur_i,
  output logic [31:0]      pc_next_o,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             jmp_i,
  input  logic [31:0]      jmp_target_i,
  input  logic             halt_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  output logic             flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             trap_o,
  output logic [31:0]      trap_addr_o
);

  seq_state_e  state;
  logic        redirect;
  logic [31:0] raw_tgt;
  logic [31:0] eff_tgt;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic        pend_load;
  logic        consume_now;
  logic        consume_pend;
  logic        cnt_inc;

  assign redirect    = br_taken_i | jmp_i;
  assign raw_tgt     = br_taken_i ? br_target_i : jmp_target_i;
  assign imem_addr_o = pc_cur_i;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam int PEND_W = 65;
  logic              misalign;
  logic [PEND_W-1:0] pend_data;
  logic              trap_hit;
  logic [31:0]       trap_tgt;

  assign misalign  = raw_tgt[1:0] != 2'b00;
  assign eff_tgt   = misalign ? TRAP_VEC : raw_tgt;
  assign pend_addr = pend_data[31:0];

  // the pending entry carries the original target so a late-consumed trap still reports it
  always_comb begin
    trap_hit = 1'b0;
    trap_tgt = raw_tgt;
    if (consume_now) begin
      trap_hit = misalign;
    end else if (consume_pend) begin
      trap_hit = pend_data[64];
      trap_tgt = pend_data[63:32];
    end
  end

  assign trap_o = trap_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_addr_o <= '0;
    end else if (trap_hit) begin
      trap_addr_o <= trap_tgt;
    end
  end

  pc_redirect_buf #(.W(PEND_W)) u_pend (
    .clk       (clk),
    .reset     (reset),
    .load      (pend_load),
    .clear     (consume_now | consume_pend),
    .load_data ({misalign, raw_tgt, eff_tgt}),
    .pend_vld  (pend_vld),
    .pend_data (pend_data)
  );
`else
  assign eff_tgt     = raw_tgt & ~32'h3;
  assign trap_o      = 1'b0;
  assign trap_addr_o = '0;

  pc_redirect_buf #(.W(32)) u_pend (
    .clk       (clk),
    .reset     (reset),
    .load      (pend_load),
    .clear     (consume_now | consume_pend),
    .load_data (eff_tgt),
    .pend_vld  (pend_vld),
    .pend_data (pend_addr)
  );
`endif

  always_comb begin
    pc_next_o    = pc_cur_i;
    flush_o      = 1'b0;
    pend_load    = 1'b0;
    consume_now  = 1'b0;
    consume_pend = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      ST_IDLE: pc_next_o = BOOT_ADDR;
      ST_FETCH: begin
        if (!halt_i) begin
          if (redirect && imem_ack_i) begin
            pc_next_o   = eff_tgt;
            flush_o     = 1'b1;
            consume_now = 1'b1;
          end else if (redirect) begin
            pend_load = 1'b1;
          end else if (imem_ack_i && stall_i) begin
            flush_o = 1'b1;
          end else if (imem_ack_i && pend_vld) begin
            pc_next_o    = pend_addr;
            flush_o      = 1'b1;
            consume_pend = 1'b1;
          end else if (imem_ack_i) begin
            pc_next_o = pc_cur_i + 32'(INSTR_BYTES);
            cnt_inc   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      imem_req_o  <= 1'b0;
      halted_o    <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_FETCH;
          imem_req_o <= 1'b1;
        end
        ST_FETCH: begin
          if (halt_i) begin
            state      <= ST_HALT;
            imem_req_o <= 1'b0;
            halted_o   <= 1'b1;
          end else if (cnt_inc) begin
            fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
